// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed seven-segment driver: single-clock slot counter, per-frame input
// snapshot, inter-digit blanking, PWM brightness and leading-zero suppression.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 100000,
    parameter int BLANK_CYCLES   = 16,
    parameter int BRIGHT_W       = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    i_clock,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic [4*NUM_DIGITS-1:0] data_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    blank_zero_i,
    input  logic [BRIGHT_W-1:0]     bright_i,
    output logic [NUM_DIGITS-1:0]   digits,
    output logic [6:0]              lcd_out,
    output logic                    dp_out,
    output logic                    frame_o
);

    localparam int          CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int          IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned STEP      = (SCAN_DIV - BLANK_CYCLES) >> BRIGHT_W;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? '1 : '0;
    localparam logic [6:0]  SEG_OFF   = SEG_ACTIVE_LOW ? '1 : '0;
    localparam logic        DP_OFF    = SEG_ACTIVE_LOW;

    logic [CNT_W-1:0]        r_slot_cnt;
    logic [IDX_W-1:0]        r_dig_idx;
    logic [4*NUM_DIGITS-1:0] r_snap_data;
    logic [NUM_DIGITS-1:0]   r_snap_dp;
    logic [BRIGHT_W-1:0]     r_snap_bright;
    logic [NUM_DIGITS-1:0]   r_snap_mask;
    logic [NUM_DIGITS-1:0]   r_digits;
    logic [6:0]              r_lcd;
    logic                    r_dp;
    logic                    r_frame;

    logic                    w_snap_now;
    logic                    w_run;
    logic [NUM_DIGITS-1:0]   w_mask_new;
    logic [4*NUM_DIGITS-1:0] w_cur_data;
    logic [NUM_DIGITS-1:0]   w_cur_dp;
    logic [NUM_DIGITS-1:0]   w_cur_mask;
    logic [BRIGHT_W-1:0]     w_cur_bright;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic [3:0]              w_nibble;
    logic                    w_dp_bit;
    logic                    w_sup;
    logic [31:0]             w_limit;
    logic                    w_in_window;
    logic                    w_on;
    logic [6:0]              w_seg;

    function automatic logic [6:0] f_decode(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign w_snap_now = enable_i && (r_slot_cnt == '0) && (r_dig_idx == '0);

    always_ff @(posedge i_clock or posedge reset_i) begin
        if (reset_i) begin
            r_slot_cnt <= '0;
            r_dig_idx  <= '0;
        end else if (!enable_i) begin
            r_slot_cnt <= '0;
            r_dig_idx  <= '0;
        end else if (r_slot_cnt == SLOT_LAST) begin
            r_slot_cnt <= '0;
            r_dig_idx  <= (r_dig_idx == IDX_LAST) ? '0 : r_dig_idx + 1'b1;
        end else begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
        end
    end

    // Walk from the most significant digit down; suppression stops at the first nonzero nibble.
    always_comb begin
        w_mask_new = '0;
        w_run      = blank_zero_i;
        for (int unsigned j = 0; j < NUM_DIGITS - 1; j++) begin
            if (data_i[4*(NUM_DIGITS-1-j) +: 4] != 4'h0) begin
                w_run = 1'b0;
            end
            w_mask_new[NUM_DIGITS-1-j] = w_run;
        end
    end

    always_ff @(posedge i_clock or posedge reset_i) begin
        if (reset_i) begin
            r_snap_data   <= '0;
            r_snap_dp     <= '0;
            r_snap_bright <= '0;
            r_snap_mask   <= '0;
        end else if (w_snap_now) begin
            r_snap_data   <= data_i;
            r_snap_dp     <= dp_i;
            r_snap_bright <= bright_i;
            r_snap_mask   <= w_mask_new;
        end
    end

    // On the snapshot cycle itself the registers still hold last frame, so bypass them.
    always_comb begin
        w_cur_data   = w_snap_now ? data_i     : r_snap_data;
        w_cur_dp     = w_snap_now ? dp_i       : r_snap_dp;
        w_cur_mask   = w_snap_now ? w_mask_new : r_snap_mask;
        w_cur_bright = w_snap_now ? bright_i   : r_snap_bright;
    end

    always_comb begin
        w_sel    = '0;
        w_nibble = 4'h0;
        w_dp_bit = 1'b0;
        w_sup    = 1'b0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (IDX_W'(k) == r_dig_idx) begin
                w_sel[k] = 1'b1;
                w_nibble = w_cur_data[4*k +: 4];
                w_dp_bit = w_cur_dp[k];
                w_sup    = w_cur_mask[k];
            end
        end
    end

    always_comb begin
        w_limit     = 32'(BLANK_CYCLES) + 32'(w_cur_bright) * STEP;
        w_in_window = (32'(r_slot_cnt) >= 32'(BLANK_CYCLES)) &&
                      ((w_cur_bright == '1) || (32'(r_slot_cnt) < w_limit));
        w_on        = enable_i && w_in_window && (!w_sup || w_dp_bit);
        w_seg       = f_decode(w_nibble);
    end

    always_ff @(posedge i_clock or posedge reset_i) begin
        if (reset_i) begin
            r_digits <= DIG_OFF;
            r_lcd    <= SEG_OFF;
            r_dp     <= DP_OFF;
            r_frame  <= 1'b0;
        end else begin
            r_frame <= w_snap_now;
            if (w_on) begin
                r_digits <= DIG_ACTIVE_LOW ? ~w_sel : w_sel;
                r_lcd    <= w_sup ? SEG_OFF : (SEG_ACTIVE_LOW ? ~w_seg : w_seg);
                r_dp     <= w_dp_bit ? ~DP_OFF : DP_OFF;
            end else begin
                r_digits <= DIG_OFF;
                r_lcd    <= SEG_OFF;
                r_dp     <= DP_OFF;
            end
        end
    end

    assign digits  = r_digits;
    assign lcd_out = r_lcd;
    assign dp_out  = r_dp;
    assign frame_o = r_frame;

endmodule
